// File: rtl/lr_shift_pkg.sv
// Shared encodings for the left/right shift SFR: shift modes, directions and FSM states.
package lr_shift_pkg;

  typedef enum logic [1:0] {
    MODE_LOG = 2'b00,
    MODE_ARI = 2'b01,
    MODE_ROT = 2'b10,
    MODE_SER = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_R = 1'b0,
    DIR_L = 1'b1
  } dir_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/shift_step_unit.sv
// Combinational one-bit shift: next register value and the bit pushed out of the far end.
module shift_step_unit
  import lr_shift_pkg::*;
#(
  parameter int unsigned SIZE = 32
) (
  input  logic [SIZE-1:0] q_i,
  input  logic            dir_i,
  input  logic [1:0]      mode_i,
  input  logic            sin_i,
  output logic [SIZE-1:0] q_next_o,
  output logic            out_bit_o
);

  logic fill_c;

  always_comb begin
    fill_c    = 1'b0;
    q_next_o  = q_i;
    out_bit_o = 1'b0;
    if (dir_e'(dir_i) == DIR_R) begin
      case (mode_e'(mode_i))
        MODE_LOG: fill_c = 1'b0;
        MODE_ARI: fill_c = q_i[SIZE-1];
        MODE_ROT: fill_c = q_i[0];
        MODE_SER: fill_c = sin_i;
        default:  fill_c = 1'b0;
      endcase
      q_next_o  = {fill_c, q_i[SIZE-1:1]};
      out_bit_o = q_i[0];
    end else begin
      // Arithmetic left is identical to logical left: zero enters the LSB.
      case (mode_e'(mode_i))
        MODE_ROT: fill_c = q_i[SIZE-1];
        MODE_SER: fill_c = sin_i;
        default:  fill_c = 1'b0;
      endcase
      q_next_o  = {q_i[SIZE-2:0], fill_c};
      out_bit_o = q_i[SIZE-1];
    end
  end

endmodule

// File: rtl/lr_shift_seq_sfr.sv
// Left/right shift SFR with single-step shifts and multi-cycle shift-by-N (busy/done handshake).
module lr_shift_seq_sfr
  import lr_shift_pkg::*;
#(
  parameter int unsigned SIZE  = 32,
  parameter int unsigned AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [SIZE-1:0]  D,
  input  logic             step,
  input  logic             start,
  input  logic [AMT_W-1:0] amt,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             sin,
  output logic [SIZE-1:0]  Q,
  output logic             sout,
  output logic             carry,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  state_e           state_q, state_d;
  logic [SIZE-1:0]  q_q, q_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [1:0]       mode_q, mode_d;

  logic             eff_dir_c;
  logic [1:0]       eff_mode_c;
  logic [SIZE-1:0]  sh_q_c;
  logic             sh_out_c;

  // While shifting, the latched command steers the shifter; otherwise the live inputs do.
  assign eff_dir_c  = (state_q == ST_SHIFT) ? dir_q  : dir;
  assign eff_mode_c = (state_q == ST_SHIFT) ? mode_q : mode;

  shift_step_unit #(.SIZE(SIZE)) u_step (
    .q_i       (q_q),
    .dir_i     (eff_dir_c),
    .mode_i    (eff_mode_c),
    .sin_i     (sin),
    .q_next_o  (sh_q_c),
    .out_bit_o (sh_out_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (ld) begin
          q_d     = D;
          carry_d = 1'b0;
        end else if (start) begin
          if (amt != '0) begin
            cnt_d   = amt;
            dir_d   = dir;
            mode_d  = mode;
            busy_d  = 1'b1;
            state_d = ST_SHIFT;
          end else begin
            done_d = 1'b1;
          end
        end else if (step) begin
          q_d     = sh_q_c;
          carry_d = sh_out_c;
        end
      end
      ST_SHIFT: begin
        if (ld) begin
          // Abort: load wins, no completion pulse.
          q_d     = D;
          carry_d = 1'b0;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          q_d     = sh_q_c;
          carry_d = sh_out_c;
          cnt_d   = cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign Q     = q_q;
  assign carry = carry_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign sout  = eff_dir_c ? q_q[SIZE-1] : q_q[0];
  assign zero  = (q_q == '0);

endmodule

// File: tb/tb_lr_shift_seq_sfr.sv
// Self-checking bench for lr_shift_seq_sfr (SIZE=8, AMT_W=5): step table, directed sequences, random runs.
module tb_lr_shift_seq_sfr;

  logic       clk, rst_n, ld, step, start, dir, sin;
  logic [7:0] D, Q;
  logic [4:0] amt;
  logic [1:0] mode;
  logic       sout, carry, busy, done, zero;

  int total = 0;
  int bad   = 0;
  logic [7:0] m_q;
  logic       m_c;

  lr_shift_seq_sfr #(.SIZE(8), .AMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .ld(ld), .D(D), .step(step), .start(start),
    .amt(amt), .dir(dir), .mode(mode), .sin(sin), .Q(Q), .sout(sout),
    .carry(carry), .busy(busy), .done(done), .zero(zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: one shift computed with plain arithmetic; returns {carry, q}.
  function automatic logic [8:0] shift1(input logic [7:0] q, input logic d,
                                        input logic [1:0] m, input logic s);
    int v;
    int fill;
    v = int'(q);
    if (!d) begin
      case (m)
        2'd0:    fill = 0;
        2'd1:    fill = int'(q[7]);
        2'd2:    fill = int'(q[0]);
        default: fill = int'(s);
      endcase
      return {q[0], 8'((v / 2) + fill * 128)};
    end else begin
      fill = (m == 2'd2) ? int'(q[7]) : (m == 2'd3) ? int'(s) : 0;
      return {q[7], 8'(((v * 2) % 256) + fill)};
    end
  endfunction

  task automatic do_ld(input logic [7:0] d);
    ld = 1'b1; D = d;
    @(negedge clk);
    ld = 1'b0;
    m_q = d; m_c = 1'b0;
    chk8("ld_q", Q, d);
    chk1("ld_carry", carry, 1'b0);
  endtask

  // Multi-cycle shift with per-cycle checks; live dir is flipped while busy to exercise the latch.
  task automatic run_shift(input int a, input logic d, input logic [1:0] m, input logic [31:0] sb);
    logic [8:0] r;
    start = 1'b1; amt = 5'(a); dir = d; mode = m;
    @(negedge clk);
    start = 1'b0;
    if (a == 0) begin
      chk1("z_done", done, 1'b1);
      chk1("z_busy", busy, 1'b0);
      chk8("z_q", Q, m_q);
      @(negedge clk);
      chk1("z_done_off", done, 1'b0);
      return;
    end
    for (int i = 0; i < a; i++) begin
      chk1("run_busy", busy, 1'b1);
      chk8("run_q_mid", Q, m_q);
      dir = ~d; mode = ~m; sin = sb[i];
      #1;
      chk1("run_sout_latched", sout, d ? m_q[7] : m_q[0]);
      @(negedge clk);
      r = shift1(m_q, d, m, sb[i]);
      m_q = r[7:0]; m_c = r[8];
    end
    chk1("run_done", done, 1'b1);
    chk1("run_busy_end", busy, 1'b0);
    chk8("run_q", Q, m_q);
    chk1("run_carry", carry, m_c);
    chk1("run_zero", zero, m_q == 8'h00);
    chk1("run_sout_live", sout, ~d ? m_q[7] : m_q[0]);
    @(negedge clk);
    chk1("run_done_off", done, 1'b0);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       dir;
    logic [1:0] mode;
    logic       sin;
    logic [7:0] exp_q;
    logic       exp_c;
  } step_vec_t;

  step_vec_t vecs[8];
  int n;
  logic [8:0] r;

  initial begin
    vecs[0] = '{8'h81, 1'b1, 2'd2, 1'b0, 8'h03, 1'b1};
    vecs[1] = '{8'h03, 1'b0, 2'd2, 1'b0, 8'h81, 1'b1};
    vecs[2] = '{8'hB4, 1'b0, 2'd1, 1'b0, 8'hDA, 1'b0};
    vecs[3] = '{8'hB4, 1'b0, 2'd0, 1'b1, 8'h5A, 1'b0};
    vecs[4] = '{8'hB4, 1'b1, 2'd1, 1'b1, 8'h68, 1'b1};
    vecs[5] = '{8'h35, 1'b1, 2'd3, 1'b1, 8'h6B, 1'b0};
    vecs[6] = '{8'h35, 1'b0, 2'd3, 1'b1, 8'h9A, 1'b1};
    vecs[7] = '{8'h01, 1'b0, 2'd0, 1'b0, 8'h00, 1'b1};

    rst_n = 1'b0; ld = 1'b0; step = 1'b0; start = 1'b0;
    D = 8'h00; amt = 5'd0; dir = 1'b0; mode = 2'd0; sin = 1'b0;
    m_q = 8'h00; m_c = 1'b0;
    #1;
    chk8("rst_q", Q, 8'h00);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_carry", carry, 1'b0);
    chk1("rst_zero", zero, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-step table
    foreach (vecs[k]) begin
      do_ld(vecs[k].d);
      step = 1'b1; dir = vecs[k].dir; mode = vecs[k].mode; sin = vecs[k].sin;
      @(negedge clk);
      step = 1'b0;
      chk8("step_q", Q, vecs[k].exp_q);
      chk1("step_carry", carry, vecs[k].exp_c);
      chk1("step_busy", busy, 1'b0);
      chk1("step_done", done, 1'b0);
      chk1("step_zero", zero, vecs[k].exp_q == 8'h00);
    end

    // ld has priority over start and step in IDLE
    do_ld(8'h11);
    ld = 1'b1; D = 8'hE7; start = 1'b1; amt = 5'd3; step = 1'b1;
    @(negedge clk);
    ld = 1'b0; start = 1'b0; step = 1'b0;
    chk8("prio_q", Q, 8'hE7);
    chk1("prio_busy", busy, 1'b0);

    // Arithmetic right by 3
    do_ld(8'hB4);
    run_shift(3, 1'b0, 2'd1, 32'h0);
    chk8("ari_q", m_q, 8'hF6);
    chk8("ari_q_dut", Q, 8'hF6);
    chk1("ari_carry", carry, 1'b1);

    // Serial fill left by 8: sin 1,0,1,0,0,1,0,1
    do_ld(8'h00);
    run_shift(8, 1'b1, 2'd3, 32'b1010_0101);
    chk8("ser_q", Q, 8'hA5);
    chk1("ser_zero", zero, 1'b0);

    // Shift by more than SIZE
    do_ld(8'hFF);
    run_shift(9, 1'b0, 2'd0, 32'h0);
    chk8("big_q", Q, 8'h00);

    // Zero amount, then start accepted in the done cycle
    dir = 1'b0; mode = 2'd0;
    do_ld(8'h5A);
    start = 1'b1; amt = 5'd0;
    @(negedge clk);
    chk1("z0_done", done, 1'b1);
    chk1("z0_busy", busy, 1'b0);
    chk8("z0_q", Q, 8'h5A);
    amt = 5'd2;
    @(negedge clk);
    start = 1'b0;
    chk1("b2b_busy", busy, 1'b1);
    chk1("b2b_done_off", done, 1'b0);
    @(negedge clk);
    chk1("b2b_busy2", busy, 1'b1);
    @(negedge clk);
    chk1("b2b_done", done, 1'b1);
    chk1("b2b_busy_end", busy, 1'b0);
    chk8("b2b_q", Q, 8'h16);

    // Abort with ld in the second busy cycle
    do_ld(8'h0F);
    start = 1'b1; amt = 5'd5; dir = 1'b0; mode = 2'd0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    ld = 1'b1; D = 8'h3C;
    @(negedge clk);
    ld = 1'b0;
    chk8("abort_q", Q, 8'h3C);
    chk1("abort_carry", carry, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_done", done, 1'b0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) n++;
    end
    chk8("abort_no_done", 8'(n), 8'd0);
    chk8("abort_hold_q", Q, 8'h3C);

    // start/step while busy are ignored
    do_ld(8'h80);
    start = 1'b1; amt = 5'd4; dir = 1'b0; mode = 2'd0;
    @(negedge clk);
    amt = 5'd1; step = 1'b1; dir = 1'b1; mode = 2'd2;
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    start = 1'b0; step = 1'b0;
    chk8("ign_busy_cycles", 8'(n), 8'd4);
    chk1("ign_done", done, 1'b1);
    chk8("ign_q", Q, 8'h08);
    chk1("ign_carry", carry, 1'b0);
    @(negedge clk);
    chk1("ign_done_off", done, 1'b0);

    // Asynchronous reset in the middle of a 5-cycle shift
    do_ld(8'hFF);
    start = 1'b1; amt = 5'd5; dir = 1'b1; mode = 2'd0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk8("arst_q", Q, 8'h00);
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    m_q = 8'h00; m_c = 1'b0;
    run_shift(1, 1'b0, 2'd2, 32'h0);

    // Randomised load / step / multi-cycle runs against the reference
    for (int it = 0; it < 30; it++) begin
      do_ld(8'($urandom));
      step = 1'b1; dir = 1'($urandom); mode = 2'($urandom); sin = 1'($urandom);
      @(negedge clk);
      step = 1'b0;
      r = shift1(m_q, dir, mode, sin);
      m_q = r[7:0]; m_c = r[8];
      chk8("rnd_step_q", Q, m_q);
      chk1("rnd_step_carry", carry, m_c);
      run_shift(int'($urandom_range(0, 12)), 1'($urandom), 2'($urandom), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lr_shift_seq_sfr.md
Name: lr_shift_seq_sfr

Overview:
- Parametrised next-generation left/right shift Special Function Register (SFR).
- Adds four shift modes: logical, arithmetic, rotate, serial-fill.
- Adds single-step shifts and multi-cycle shift-by-N commands with a busy/done handshake.
- Provides carry-out, serial-out and zero flags.
- Sits on the datapath SFR bus; the controller issues ld/step/start and polls busy or waits on done.

Parameters:
SIZE, 32, register width in bits (SIZE >= 2)
AMT_W, 5, width of the shift-amount field; max amount 2^AMT_W-1 (may exceed SIZE)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
ld  in  1  parallel load of D (highest priority)
D  in  SIZE  parallel load data
step  in  1  one immediate shift using dir/mode/sin (IDLE only)
start  in  1  begin multi-cycle shift by amt (IDLE only)
amt  in  AMT_W  shift count for start
dir  in  1  0 = right, 1 = left
mode  in  2  00 logical, 01 arithmetic, 10 rotate, 11 serial-fill
sin  in  1  fill bit for serial-fill mode, sampled every shifting cycle
Q  out  SIZE  register contents
sout  out  1  combinational: Q[0] if effective dir = right, else Q[SIZE-1]
carry  out  1  last bit shifted out
busy  out  1  multi-cycle shift in progress
done  out  1  one-cycle completion pulse
zero  out  1  combinational (Q == 0)

Behaviour:
- Reset (rst_n low, asynchronous): Q=0, carry=0, busy=0, done=0, count=0, state IDLE, latched dir/mode=0.
- States:
  - IDLE: no shift in progress.
  - SHIFT: count, dir and mode were latched at start.
- One-step shift function:
  - Right: logical fills MSB with 0; arithmetic fills MSB with Q[SIZE-1]; rotate fills MSB with Q[0]; serial fills MSB with sin. carry <= Q[0].
  - Left: logical and arithmetic fill LSB with 0; rotate fills LSB with Q[SIZE-1]; serial fills LSB with sin. carry <= Q[SIZE-1].
- Priority in IDLE: ld > start > step.
  - ld: Q<=D, carry<=0.
  - start, amt!=0: latch amt/dir/mode, count<=amt, enter SHIFT, busy=1 from next cycle. No shift is performed on the start edge.
  - start, amt==0: no shift; done=1 for the next cycle; busy stays 0.
  - step: one shift with the live dir/mode/sin; no busy, no done.
- SHIFT state:
  - Every cycle performs one shift with the latched dir/mode and live sin; count decrements.
  - On the edge where count==1: final shift, state->IDLE, busy<=0, done<=1 for exactly one cycle.
  - amt=N gives busy high for N cycles. Q is final in the cycle where done=1.
- In SHIFT, ld aborts: Q<=D, carry<=0, busy<=0, state->IDLE, no done pulse.
- In SHIFT, start and step are ignored.
- done is a pulse only; it deasserts the following cycle regardless of inputs.
- A new start is accepted in the cycle done is high, because the block is in IDLE.
- Amounts >= SIZE are legal and shift literally, one bit per cycle. Example: logical shift by SIZE yields 0.
- sout uses the latched dir while busy, the live dir otherwise.

Decomposition:
- Package lr_shift_pkg: mode encodings (MODE_LOG, MODE_ARI, MODE_ROT, MODE_SER), dir encodings (DIR_R, DIR_L), state encoding (ST_IDLE, ST_SHIFT).
- Sub-module shift_step_unit: combinational, parameter SIZE. Inputs Q, dir, mode, sin. Outputs next Q and the out bit.
- Top level holds the FSM, counter, flags and register.

Test Plan (SIZE=8, AMT_W=5):
- Reset: pulse rst_n low in the middle of a 5-cycle shift -> Q=0x00, busy=0, done=0 immediately, before the next clk edge. start is accepted on the first edge after rst_n high.
- Arithmetic right: ld D=0xB4, then start amt=3 dir=0 mode=01 -> busy high 3 cycles; Q=0xF6, carry=1, done=1 for one cycle.
- Rotate step: ld D=0x81, then step dir=1 mode=10 -> Q=0x03, carry=1, busy never asserted. A second step dir=0 gives Q=0x81, carry=1.
- Serial fill: Q=0x00, start amt=8 dir=1 mode=11, sin sequence 1,0,1,0,0,1,0,1 over the shifting cycles -> Q=0xA5, zero=0, done after 8 busy cycles.
- Zero-amount and back-to-back:
  - start amt=0 -> done=1 next cycle, busy=0, Q unchanged.
  - start amt=2 issued in the done cycle -> accepted.
- Abort/ignore: start amt=5 with ld D=0x3C asserted in the 2nd busy cycle -> Q=0x3C, carry=0, busy=0, no done. start/step asserted while busy (no ld) -> ignored, count unaffected.
